// File: rtl/conv_arbiter_pkg.sv
// Shared types and constants for the two-client converter arbiter.
package conv_arbiter_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ID_W    = 2;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    REL   = 3'd4
  } state_e;

  typedef enum logic [ID_W-1:0] {
    C1 = 2'd1,
    C2 = 2'd2
  } client_e;

endpackage

// File: rtl/conv_arbiter_if.sv
// Client req/ack pairs, converter soc/eoc handshake and the data paths.
interface conv_arbiter_if;
  import conv_arbiter_pkg::*;

  logic  req1;
  logic  req2;
  logic  ack1;
  logic  ack2;
  data_t dout;
  logic  soc;
  logic  eoc;
  data_t x;

  // master: clients plus converter; slave: the arbiter
  modport master (output req1, req2, eoc, x, input ack1, ack2, dout, soc);
  modport slave  (input req1, req2, eoc, x, output ack1, ack2, dout, soc);

endinterface

// File: rtl/conv_arbiter_rr_pick.sv
// Combinational round-robin picker: on a tie the client that was not served last wins.
module conv_arbiter_rr_pick
  import conv_arbiter_pkg::*;
(
  input  logic    req1,
  input  logic    req2,
  input  client_e last,
  output logic    grant_c,
  output client_e winner_c
);

  always_comb begin
    grant_c  = req1 | req2;
    winner_c = C1;
    if (req1 && req2) begin
      winner_c = (last == C1) ? C2 : C1;
    end else if (req2) begin
      winner_c = C2;
    end
  end

endmodule

// File: rtl/conv_arbiter.sv
// Shares one soc/eoc converter between two 4-phase clients with round-robin arbitration.
module conv_arbiter
  import conv_arbiter_pkg::*;
(
  input  logic           clock,
  input  logic           reset_,
  conv_arbiter_if.slave  bus
);

  state_e  state;
  client_e g;
  client_e last;
  logic    soc;
  logic    ack1;
  logic    ack2;
  data_t   dout;

  logic    pick_valid_c;
  client_e pick_c;
  logic    req_g_c;

  conv_arbiter_rr_pick u_pick (
    .req1     (bus.req1),
    .req2     (bus.req2),
    .last     (last),
    .grant_c  (pick_valid_c),
    .winner_c (pick_c)
  );

  assign req_g_c = (g == C1) ? bus.req1 : bus.req2;

  // Sequencer: grants only while the converter reports idle, outputs are registered
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      g     <= C1;
      last  <= C2;
      soc   <= 1'b0;
      ack1  <= 1'b0;
      ack2  <= 1'b0;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.eoc && pick_valid_c) begin
            g     <= pick_c;
            soc   <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (!bus.eoc) begin
            soc   <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.eoc) begin
            dout  <= bus.x;
            ack1  <= (g == C1);
            ack2  <= (g == C2);
            state <= ACK;
          end
        end
        ACK: begin
          if (!req_g_c) begin
            ack1  <= 1'b0;
            ack2  <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          last  <= g;
          state <= IDLE;
        end
        default: begin
          soc   <= 1'b0;
          ack1  <= 1'b0;
          ack2  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.soc  = soc;
  assign bus.ack1 = ack1;
  assign bus.ack2 = ack2;
  assign bus.dout = dout;

endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter with a behavioural converter and a random traffic phase.
module tb_conv_arbiter;
  import conv_arbiter_pkg::*;

  logic clock;
  logic reset_;
  conv_arbiter_if bus ();

  conv_arbiter dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // converter model controls
  int          fall_dly = 1;
  int          rise_dly = 1;
  logic [7:0]  conv_val = 8'h00;
  bit          busy_hold = 1'b0;
  bit          mon_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic ack_of(input int c);
    return (c == 1) ? bus.ack1 : bus.ack2;
  endfunction

  task automatic set_req(input int c, input logic v);
    if (c == 1) bus.req1 = v;
    else        bus.req2 = v;
  endtask

  // Wait for client c's ack, check data, then run the release half of the handshake.
  task automatic serve(input int c, input logic [7:0] v, input logic [7:0] nv,
                       input bit rereq, output int n);
    n = 0;
    while (ack_of(c) !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("ack_rise", ack_of(c), 1);
    chk("other_ack", ack_of(3 - c), 0);
    chk("dout", bus.dout, v);
    conv_val = nv;
    set_req(c, 1'b0);
    tick();
    chk("ack_fall", ack_of(c), 0);
    if (rereq) set_req(c, 1'b1);
    tick();
  endtask

  // Converter: eoc falls fall_dly edges after soc is seen, rises rise_dly edges later.
  initial begin
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    bus.eoc = 1'b1;
    bus.x = 8'h00;
    forever begin
      @(posedge clock);
      #2;
      if (busy_hold) begin
        bus.eoc = 1'b0;
        ph = 3;
      end else if (ph == 3) begin
        bus.eoc = 1'b1;
        ph = 0;
      end else if (ph == 2) begin
        cnt--;
        if (cnt == 0) begin
          bus.eoc = 1'b1;
          bus.x = conv_val;
          ph = 0;
        end
      end else begin
        if (ph == 0 && bus.soc && bus.eoc) begin
          ph = 1;
          cnt = fall_dly;
        end
        if (ph == 1) begin
          cnt--;
          if (cnt == 0) begin
            bus.eoc = 1'b0;
            ph = 2;
            cnt = rise_dly;
          end
        end
      end
    end
  end

  // Exclusion invariants checked every cycle
  always @(negedge clock) begin
    if (mon_en) begin
      chk("ack_excl", bus.ack1 & bus.ack2, 0);
      chk("soc_ack_excl", bus.soc & (bus.ack1 | bus.ack2), 0);
    end
  end

  initial begin
    int n;
    int hi;
    int k;
    int raised1, raised2, served1, served2;
    raised1 = 0; raised2 = 0; served1 = 0; served2 = 0;

    reset_ = 1'b0;
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    mon_en = 1'b1;
    tick();
    tick();
    chk("rst_soc", bus.soc, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_ack2", bus.ack2, 0);
    chk("rst_dout", bus.dout, 8'h00);
    reset_ = 1'b1;
    tick();

    // single request, 2-cycle eoc delays
    fall_dly = 2; rise_dly = 2; conv_val = 8'h5A;
    bus.req1 = 1'b1;
    tick();
    chk("single_soc", bus.soc, 1);
    chk("single_ack1_early", bus.ack1, 0);
    serve(1, 8'h5A, 8'h11, 1'b0, n);
    chk("single_latency", n + 1, 5);

    // tie out of reset, then alternation
    reset_ = 1'b0;
    #1;
    tick();
    reset_ = 1'b1;
    tick();
    fall_dly = 1; rise_dly = 1;
    bus.req1 = 1'b1;
    bus.req2 = 1'b1;
    serve(1, 8'h11, 8'h22, 1'b1, n);
    chk("ideal_latency", n, 3);
    serve(2, 8'h22, 8'h33, 1'b1, n);
    serve(1, 8'h33, 8'h44, 1'b0, n);
    serve(2, 8'h44, 8'h77, 1'b0, n);

    // early withdrawal during WAIT
    fall_dly = 1; rise_dly = 3;
    bus.req2 = 1'b1;
    tick();
    chk("wd_soc", bus.soc, 1);
    tick();
    chk("wd_wait_soc", bus.soc, 0);
    bus.req2 = 1'b0;
    hi = 0;
    repeat (8) begin
      tick();
      if (bus.ack2) begin
        hi++;
        chk("wd_dout", bus.dout, 8'h77);
      end
    end
    chk("wd_ack2_cycles", hi, 1);

    // busy converter holds off soc
    busy_hold = 1'b1;
    tick();
    tick();
    bus.req1 = 1'b1;
    hi = 0;
    repeat (4) begin
      tick();
      if (bus.soc) hi++;
    end
    chk("busy_no_soc", hi, 0);
    busy_hold = 1'b0;
    fall_dly = 1; rise_dly = 1; conv_val = 8'h3C;
    serve(1, 8'h3C, 8'hC3, 1'b0, n);

    // reset mid-WAIT with eoc low
    fall_dly = 1; rise_dly = 5;
    bus.req1 = 1'b1;
    tick();
    tick();
    chk("mid_wait_soc", bus.soc, 0);
    busy_hold = 1'b1;
    reset_ = 1'b0;
    #1;
    chk("async_soc", bus.soc, 0);
    chk("async_ack1", bus.ack1, 0);
    chk("async_ack2", bus.ack2, 0);
    chk("async_dout", bus.dout, 8'h00);
    tick();
    tick();
    reset_ = 1'b1;
    hi = 0;
    repeat (4) begin
      tick();
      if (bus.soc) hi++;
    end
    chk("post_rst_no_soc", hi, 0);
    fall_dly = 1; rise_dly = 1;
    busy_hold = 1'b0;
    serve(1, 8'hC3, 8'h00, 1'b0, n);

    // random 4-phase traffic
    for (int i = 0; i < 10000; i++) begin
      tick();
      fall_dly = int'($urandom_range(1, 3));
      rise_dly = int'($urandom_range(1, 3));
      conv_val = 8'($urandom);
      if (!bus.req1 && !bus.ack1 && $urandom_range(0, 3) == 0) begin
        bus.req1 = 1'b1; raised1++;
      end else if (bus.req1 && bus.ack1 && $urandom_range(0, 1) == 0) begin
        chk("rnd_dout1", bus.dout, bus.x);
        bus.req1 = 1'b0; served1++;
      end
      if (!bus.req2 && !bus.ack2 && $urandom_range(0, 3) == 0) begin
        bus.req2 = 1'b1; raised2++;
      end else if (bus.req2 && bus.ack2 && $urandom_range(0, 1) == 0) begin
        chk("rnd_dout2", bus.dout, bus.x);
        bus.req2 = 1'b0; served2++;
      end
    end

    // drain outstanding requests
    k = 0;
    while ((bus.req1 || bus.req2) && k < 400) begin
      tick();
      k++;
      if (bus.req1 && bus.ack1) begin bus.req1 = 1'b0; served1++; end
      if (bus.req2 && bus.ack2) begin bus.req2 = 1'b0; served2++; end
    end
    chk("drain_req1", bus.req1, 0);
    chk("drain_req2", bus.req2, 0);
    chk("served1", served1, raised1);
    chk("served2", served2, raised2);
    tick();
    tick();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
